phi3_sbox_sequencer: RTL and testbench
======================================

// Module: phi3_sbox_sequencer
// PURPOSE
//  Evaluates a 3-in / NOUT-out S-box one coordinate function per cycle over a single
//  internal phi3 instance (all 256 Boolean functions of 3 vars, indexed by truth table).
//  Each output bit k selects z[tt[k]], where tt[k] is an 8-bit truth table held in config regs.
//  Sits between a valid/ready requester and a consumer; owns the truth-table config.
// PARAMETERS
//  NOUT   3   number of output coordinate functions, legal 1..8
//  KW     3   width of bit counter k, must hold NOUT-1
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  cfg_we     in   1     truth-table write strobe
//  cfg_idx    in   3     output bit index to write
//  cfg_tt     in   8     truth table (phi3 index) for that bit
//  cfg_ok     out  1     config writes accepted this cycle (state==IDLE)
//  in_valid   in   1     request valid
//  in_ready   out  1     request accepted when in_valid & in_ready
//  in_x       in   3     S-box input, sampled on acceptance
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  out_y      out  NOUT  S-box output, bit k = tt[k][x]
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, k=0, x_reg=0, y_reg=0, out_valid=0, busy=0,
//   in_ready=1, cfg_ok=1; tt[0]=8'hAA, tt[1]=8'hCC, tt[2]=8'hF0, tt[3..NOUT-1]=8'h00
//   (identity projections of x for bits 0..2).
//  FSM IDLE -> EVAL -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid: x_reg<=in_x, k<=0, y_reg<=0, -> EVAL.
//  EVAL: phi3 driven by x_reg; y_reg[k]<=z[tt[k]]; if k==NOUT-1 -> DONE else k<=k+1.
//   Exactly NOUT EVAL cycles; in_ready=0.
//  DONE: out_valid=1, out_y=y_reg stable; in_ready=0. On out_ready -> IDLE (out_valid drops
//   next cycle). out_ready held low: stay in DONE indefinitely, nothing changes.
//  Latency: acceptance edge t0 -> out_valid high after edge t0+NOUT (NOUT+1 cycles after
//   request presented). Throughput: one result per NOUT+2 cycles with out_ready=1.
//  out_y outside DONE is don't-care for consumers but must equal y_reg (no glitching mux).
//  Config: write tt[cfg_idx]<=cfg_tt when cfg_we & cfg_ok & cfg_idx<NOUT.
//   cfg_idx>=NOUT: ignored. cfg_we while busy: ignored (no queueing) so an in-flight
//   evaluation always uses one consistent table set.
//  Simultaneous cfg_we and in_valid in IDLE: both take effect; the evaluation uses the
//   newly written table (write lands on same edge as acceptance, EVAL starts next cycle).
//  in_valid while busy: not accepted, no side effects; requester must hold.
//  rst mid-EVAL/DONE: result discarded, config returns to reset tables.
// TESTING
//  1 Reset, NOUT=3, in_x=3'b101, out_ready=1 -> out_valid after 4 edges, out_y=3'b101.
//  2 Load tt0=8'h96, tt1=8'hE8, tt2=8'h01; in_x=3'b011 -> out_y=3'b010;
//    in_x=3'b000 -> out_y=3'b100.
//  3 out_ready=0 for 5 cycles in DONE -> out_valid=1, out_y stable; in_valid=1 with
//    in_x=3'b111 meanwhile not accepted (in_ready=0).
//  4 cfg_we tt0=8'h00 during EVAL -> ignored, result uses old tt0;
//    cfg_idx=5 in IDLE (NOUT=3) -> no register changes.
//  5 Assert rst on 2nd EVAL cycle -> out_valid=0, in_ready=1 immediately; next request
//    with in_x=3'b110 returns 3'b110 (identity tables restored).
//  6 Random tables, all 8 inputs back-to-back, random out_ready stalls -> out_y[k]==tt[k][x]
//    for every transaction, none lost or duplicated.

Source files
------------

// File: rtl/phi3_sbox_sequencer.sv
// Bit-serial 3-input S-box. One phi3 instance is shared by all outputs, and each
// output bit k is evaluated on its own cycle using the truth table held in tt[k].

// phi3: the bank of all 256 Boolean functions of 3 variables. z[i] = bit x of i.
module phi3 (
    input  logic [2:0]   x,
    output logic [255:0] z
);
    for (genvar i = 0; i < 256; i++) begin : g_fn
        localparam logic [7:0] TT = 8'(i);
        assign z[i] = TT[x];
    end
endmodule

module phi3_sbox_sequencer #(
    parameter int NOUT = 3,
    parameter int KW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_idx,
    input  logic [7:0]      cfg_tt,
    output logic            cfg_ok,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NOUT-1:0] out_y,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    localparam logic [KW-1:0] K_LAST = KW'(NOUT - 1);

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [2:0]            x_q, x_d;
    logic [NOUT-1:0]       y_q, y_d;
    logic [NOUT-1:0][7:0]  tt_q, tt_d;

    logic [255:0]          z;
    logic [7:0]            tt_sel;
    logic                  cfg_hit;

    // Reset tables make bits 0..2 the identity projections of x.
    function automatic logic [7:0] tt_rst(input int i);
        case (i)
            0:       return 8'hAA;
            1:       return 8'hCC;
            2:       return 8'hF0;
            default: return 8'h00;
        endcase
    endfunction

    phi3 u_phi3 (.x(x_q), .z(z));

    // Explicit compare-select keeps the k index in range for any NOUT/KW pairing.
    always_comb begin
        tt_sel = tt_q[0];
        for (int i = 0; i < NOUT; i++)
            if (k_q == KW'(i)) tt_sel = tt_q[i];
    end

    // Writes only land in IDLE so an in-flight evaluation sees one consistent table set.
    assign cfg_hit = cfg_we && (state_q == IDLE) && ({1'b0, cfg_idx} < 4'(NOUT));

    always_comb begin
        tt_d = tt_q;
        for (int i = 0; i < NOUT; i++)
            if (cfg_hit && cfg_idx == 3'(i)) tt_d[i] = cfg_tt;
    end

    always_comb begin
        k_d = k_q;
        x_d = x_q;
        y_d = y_q;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d = in_x;
                k_d = '0;
                y_d = '0;
            end
            EVAL: begin
                for (int i = 0; i < NOUT; i++)
                    if (k_q == KW'(i)) y_d[i] = z[tt_sel];
                if (k_q != K_LAST) k_d = k_q + KW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            for (int i = 0; i < NOUT; i++) tt_q[i] <= tt_rst(i);
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tt_q    <= tt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EVAL;
            EVAL:    if (k_q == K_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        cfg_ok    = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    assign out_y = y_q;

endmodule

// File: tb/tb_phi3_sbox_sequencer.sv
// Directed bench for phi3_sbox_sequencer (NOUT=3) with hand-computed S-box results.
module tb_phi3_sbox_sequencer;
    localparam int NOUT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [2:0]      cfg_idx;
    logic [7:0]      cfg_tt;
    logic            cfg_ok;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_x;
    logic            out_valid;
    logic            out_ready;
    logic [NOUT-1:0] out_y;
    logic            busy;

    int n_vec = 0;
    int n_bad = 0;

    phi3_sbox_sequencer #(.NOUT(NOUT), .KW(3)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_tt(cfg_tt), .cfg_ok(cfg_ok),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [7:0] tt);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_tt  = tt;
        tick();
        cfg_we  = 1'b0;
    endtask

    // One request: check acceptance, latency, result, optional DONE stall, and release.
    task automatic run_req(input string tag, input logic [2:0] x, input logic [2:0] exp_y,
                           input int stall, input bit poke);
        int lat;
        chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_x      = x;
        out_ready = (stall == 0);
        tick();
        in_valid  = 1'b0;
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(NOUT));
        chk({tag, "/out_y"}, 32'(out_y), 32'(exp_y));
        if (poke) begin
            in_valid = 1'b1;
            in_x     = 3'b111;
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, "/stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "/stall_y"}, 32'(out_y), 32'(exp_y));
            chk({tag, "/stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk({tag, "/release_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "/release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [7:0] m_tt [NOUT];
    logic [2:0] exp_y;
    logic [2:0] xv;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_tt = '0;
        in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        #12;
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        chk("rst/cfg_ok", 32'(cfg_ok), 32'd1);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/out_y", 32'(out_y), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Identity tables after reset
        run_req("t1", 3'b101, 3'b101, 0, 1'b0);

        // xor3 / majority / nor3
        cfg_write(3'd0, 8'h96);
        cfg_write(3'd1, 8'hE8);
        cfg_write(3'd2, 8'h01);
        run_req("t2a", 3'b011, 3'b010, 0, 1'b0);
        run_req("t2b", 3'b000, 3'b100, 0, 1'b0);

        // Long DONE stall with a competing request held high
        run_req("t3", 3'b011, 3'b010, 5, 1'b1);

        // Config write during EVAL must be ignored: bit2 would flip to 1 with tt2=FF
        in_valid = 1'b1; in_x = 3'b001; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4/cfg_ok_busy", 32'(cfg_ok), 32'd0);
        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_tt = 8'hFF;
        tick();
        tick();
        cfg_we = 1'b0;
        tick();
        chk("t4/eval_valid", 32'(out_valid), 32'd1);
        chk("t4/eval_y", 32'(out_y), 32'd1);
        tick();
        chk("t4/eval_release", 32'(out_valid), 32'd0);
        run_req("t4b", 3'b000, 3'b100, 0, 1'b0);
        // Out-of-range index leaves every table untouched
        cfg_write(3'd5, 8'h00);
        run_req("t4c", 3'b001, 3'b001, 0, 1'b0);
        run_req("t4d", 3'b111, 3'b011, 0, 1'b0);

        // Write and request on the same edge: evaluation sees the new tt0
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_tt = 8'h00;
        run_req("t4e", 3'b001, 3'b000, 0, 1'b0);
        cfg_we = 1'b0;

        // Reset on the second EVAL cycle
        in_valid = 1'b1; in_x = 3'b011;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t5/out_valid", 32'(out_valid), 32'd0);
        chk("t5/in_ready", 32'(in_ready), 32'd1);
        chk("t5/busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_req("t5b", 3'b110, 3'b110, 0, 1'b0);

        // Random tables, all eight inputs, random stalls
        for (int k = 0; k < NOUT; k++) begin
            m_tt[k] = 8'($urandom);
            cfg_write(3'(k), m_tt[k]);
        end
        for (int x = 0; x < 8; x++) begin
            xv = 3'(x);
            for (int k = 0; k < NOUT; k++) exp_y[k] = m_tt[k][xv];
            run_req($sformatf("t6/x%0d", x), xv, exp_y, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
